relay_sequencer_fsm: RTL and testbench
======================================

Name: relay_sequencer_fsm

Overview:
- Instruction-cycle sequencer for the relay computer. Drives the one-hot state vector (state_1..state_24) that the decode logic turns into control signals.
- Consumes the 4-bit instruction-class code the decode logic returns during state_4, and the decoded Halt signal.
- Sets the per-class sequence length: next state, wrap to fetch, or park in IDLE.

Parameters:
- NUM_STATES, 24, width of one-hot state vector; bit 0 = state_1.
- LAST_SHORT, 7, final state of MOV-8 / SETAB / ALU class.
- LAST_LDST, 11, final state of LOAD/STORE class.
- LAST_MOV16, 10, final state of MOV-16 / HALT / RETURN class.
- LAST_INC, 14, final state of INC class.
- LAST_GOTO, 24, final state of GOTO/CALL/BRANCH class.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high; forces IDLE
- step_en  in  1  advance qualifier (relay-speed tick); state changes only on edges with step_en=1
- start  in  1  leaves IDLE into state_1; ignored when not in IDLE
- fsm_input  in  4  instruction class from decode; valid only while state_4 is active
- halt_req  in  1  decode's Halt control signal
- state  out  NUM_STATES  one-hot current state; all-zero in IDLE
- halted  out  1  1 while in IDLE
- instr_done  out  1  one-clock pulse on the edge that retires an instruction (wrap to state_1 or entry to IDLE)
- illegal_class  out  1  sticky; set when an unrecognised class is latched

Behaviour:
- Reset (async, any time, including mid-instruction): state=0, halted=1, instr_done=0, illegal_class=0, class_q=SHORT.
- Internal state: an index 0..24, where 0 = IDLE and n = state_n, plus the registered class_q. state[n-1] = (index==n). The one-hot vector is decoded from the registered index with no combinational path from inputs, so exactly zero or one bit of state is high at any time.
- IDLE: on an edge with start=1 and step_en=1, go to state_1 and set halted=0. Otherwise hold.
- Common fetch: state_1 -> 2 -> 3 -> 4, one state per step_en edge.
- Class latch: on the edge leaving state_4, class_q captures the decoded fsm_input.
  - 0000 or 0100 or 1000 -> SHORT
  - 1001 -> LDST
  - 1010 -> MOV16
  - 1011 -> INC
  - 11xx -> GOTO
  - any other code -> SHORT, and illegal_class is set.
- class_q is held constant until the next pass through state_4.
- Execute: from state_n with n < LAST(class_q), go to state_n+1.
- At state_n with n == LAST(class_q):
  - next state is state_1, with instr_done pulsed;
  - exception: class_q=MOV16 and halt_latched=1 -> next state is IDLE, with halted=1 and instr_done pulsed.
- Halt latch: halt_latched is set on any step_en edge where halt_req=1 and index is 9 or 10. It is cleared on entry to state_1 and on reset. halt_req in any other state is ignored.
- step_en=0: state, class_q and halt_latched are held. instr_done is 0.
- start during a running sequence has no effect.
- instr_done is high only for the single clock following the retiring edge.

Test Plan:
- Reset then start=1, step_en=1 continuously; fsm_input=0000 at state_4 -> state walks 0x000001, 0x000002 .. 0x000040 (state_7), then 0x000001, with one instr_done pulse; halted=0.
- fsm_input=1001 -> states 1..11 then back to state_1; fsm_input=1011 -> states 1..14 then back to state_1; fsm_input=1100 -> states 1..24 (0x800000) then back to state_1.
- fsm_input=1010, halt_req=1 during state_9 -> state_10 then state=0, halted=1, instr_done pulse; a later start=1 restarts at state_1.
- step_en toggled 1,0,0,1 in state_5 -> state_5 is held for the two idle edges, then advances to state_6; no instr_done during the hold.
- Assert reset during state_17 of a GOTO, asynchronously between clock edges -> state=0 and halted=1 immediately, without waiting for a clock; illegal_class=0.
- fsm_input=0011 at state_4 -> illegal_class=1 (sticky), sequence behaves as SHORT (wraps after state_7); fsm_input changes outside state_4 do not alter sequence length.

Source files
------------

// File: rtl/relay_sequencer_fsm_if.sv
// Control/status bundle between the relay decode logic
// and the instruction-cycle sequencer.
interface relay_sequencer_fsm_if #(
  parameter int NUM_STATES = 24
);
  logic                  step_en;
  logic                  start;
  logic [3:0]            fsm_input;
  logic                  halt_req;
  logic [NUM_STATES-1:0] state;
  logic                  halted;
  logic                  instr_done;
  logic                  illegal_class;

  modport master (
    output step_en, start, fsm_input, halt_req,
    input  state, halted, instr_done, illegal_class
  );

  modport slave (
    input  step_en, start, fsm_input, halt_req,
    output state, halted, instr_done, illegal_class
  );
endinterface

// File: rtl/relay_sequencer_fsm.sv
// Relay computer instruction-cycle sequencer: walks a
// one-hot state vector whose length depends on the class.
module relay_sequencer_fsm #(
  parameter int NUM_STATES = 24,
  parameter int LAST_SHORT = 7,
  parameter int LAST_LDST  = 11,
  parameter int LAST_MOV16 = 10,
  parameter int LAST_INC   = 14,
  parameter int LAST_GOTO  = 24
) (
  input logic                  clock,
  input logic                  reset,
  relay_sequencer_fsm_if.slave bus
);
  localparam int IW = $clog2(NUM_STATES + 1);

  typedef enum logic [2:0] {
    SHORT,
    LDST,
    MOV16,
    INC,
    GOTO
  } class_e;

  logic [IW-1:0] idx_q, idx_d, last;
  class_e        cls_q, cls_d;
  logic          hlt_q, hlt_d;
  logic          ill_q, ill_d;
  logic          done_q, done_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx_q  <= '0;
      cls_q  <= SHORT;
      hlt_q  <= 1'b0;
      ill_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      cls_q  <= cls_d;
      hlt_q  <= hlt_d;
      ill_q  <= ill_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    last = IW'(LAST_SHORT);
    unique case (cls_q)
      SHORT:   last = IW'(LAST_SHORT);
      LDST:    last = IW'(LAST_LDST);
      MOV16:   last = IW'(LAST_MOV16);
      INC:     last = IW'(LAST_INC);
      GOTO:    last = IW'(LAST_GOTO);
      default: last = IW'(LAST_SHORT);
    endcase
  end

  always_comb begin
    idx_d  = idx_q;
    cls_d  = cls_q;
    hlt_d  = hlt_q;
    ill_d  = ill_q;
    done_d = 1'b0;
    if (bus.step_en) begin
      if (bus.halt_req &&
          (idx_q == IW'(9) || idx_q == IW'(10)))
        hlt_d = 1'b1;
      // Entering state_1 clears the halt latch, so it
      // overrides a halt_req seen on the same edge.
      if (idx_q == '0) begin
        if (bus.start) begin
          idx_d = IW'(1);
          hlt_d = 1'b0;
        end
      end else if (idx_q == IW'(4)) begin
        idx_d = IW'(5);
        casez (bus.fsm_input)
          4'b0000,
          4'b0100,
          4'b1000: cls_d = SHORT;
          4'b1001: cls_d = LDST;
          4'b1010: cls_d = MOV16;
          4'b1011: cls_d = INC;
          4'b11??: cls_d = GOTO;
          default: begin
            cls_d = SHORT;
            ill_d = 1'b1;
          end
        endcase
      end else if (idx_q >= last) begin
        done_d = 1'b1;
        if (cls_q == MOV16 && hlt_q) begin
          idx_d = '0;
        end else begin
          idx_d = IW'(1);
          hlt_d = 1'b0;
        end
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end
  end

  always_comb begin
    bus.state = '0;
    for (int i = 0; i < NUM_STATES; i++)
      bus.state[i] = (idx_q == IW'(i + 1));
  end

  assign bus.halted        = (idx_q == '0);
  assign bus.instr_done    = done_q;
  assign bus.illegal_class = ill_q;
endmodule

// File: tb/tb_relay_sequencer_fsm.sv
// Self-checking bench for relay_sequencer_fsm: constant
// vectors, directed corner cases and a random model run.
module tb_relay_sequencer_fsm;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  relay_sequencer_fsm_if #(.NUM_STATES(24)) bus();

  relay_sequencer_fsm dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Reference: position 0 = IDLE, n = state_n; the
  // instruction length is looked up straight from the code.
  int m_pos, m_len;
  bit m_hl, m_ill, m_done;

  task automatic model_reset();
    m_pos = 0; m_len = 7; m_hl = 0;
    m_ill = 0; m_done = 0;
  endtask

  task automatic model_step(bit se, bit st,
                            logic [3:0] fi, bit hr);
    bit nh;
    m_done = 0;
    if (!se) return;
    nh = m_hl || (hr && (m_pos == 9 || m_pos == 10));
    if (m_pos == 0) begin
      if (st) m_pos = 1;
    end else if (m_pos == 4) begin
      if (fi == 4'b1001) m_len = 11;
      else if (fi == 4'b1010) m_len = 10;
      else if (fi == 4'b1011) m_len = 14;
      else if (fi[3:2] == 2'b11) m_len = 24;
      else begin
        m_len = 7;
        if (fi != 4'b0000 && fi != 4'b0100 &&
            fi != 4'b1000) m_ill = 1;
      end
      m_pos = 5;
    end else if (m_pos == m_len) begin
      m_done = 1;
      m_pos = (m_len == 10 && m_hl) ? 0 : 1;
    end else begin
      m_pos++;
    end
    m_hl = (m_pos == 1) ? 1'b0 : nh;
  endtask

  task automatic check(string nm, logic [31:0] act,
                       logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [23:0] onehot(int p);
    logic [23:0] v;
    v = '0;
    if (p > 0) v[p-1] = 1'b1;
    return v;
  endfunction

  task automatic compare_model();
    check("state", 32'(bus.state), 32'(onehot(m_pos)));
    check("halted", 32'(bus.halted), 32'(m_pos == 0));
    check("instr_done", 32'(bus.instr_done), 32'(m_done));
    check("illegal", 32'(bus.illegal_class), 32'(m_ill));
  endtask

  task automatic cyc(bit se, bit st, logic [3:0] fi,
                     bit hr);
    bus.step_en   = se;
    bus.start     = st;
    bus.fsm_input = fi;
    bus.halt_req  = hr;
    @(posedge clock);
    model_step(se, st, fi, hr);
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // Runs from state_1 until the next retire; code is only
  // presented during state_4, other codes elsewhere.
  task automatic run_instr(logic [3:0] code,
                           logic [3:0] other,
                           output int n);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      cyc(1'b1, 1'b0, (m_pos == 4) ? code : other,
          1'b0);
      n++;
      if (m_pos <= 1) return;
    end
    errors++;
    $display("FAIL run_instr timeout code=%0b", code);
  endtask

  typedef struct {
    bit          se;
    bit          st;
    logic [3:0]  fi;
    logic [23:0] exp_state;
    bit          exp_done;
  } vec_t;

  typedef struct {
    logic [3:0] code;
    int         len;
  } len_t;

  vec_t tbl[9];
  len_t lens[3];
  int   n;

  initial begin
    tbl[0] = '{1'b1, 1'b1, 4'h0, 24'h000001, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 4'h0, 24'h000002, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 4'h0, 24'h000004, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 4'h0, 24'h000008, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 4'h0, 24'h000010, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 4'h0, 24'h000020, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 4'h0, 24'h000040, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 4'h0, 24'h000001, 1'b1};
    tbl[8] = '{1'b1, 1'b1, 4'h0, 24'h000002, 1'b0};
    lens[0] = '{4'b1001, 11};
    lens[1] = '{4'b1011, 14};
    lens[2] = '{4'b1100, 24};

    bus.step_en = 0; bus.start = 0;
    bus.fsm_input = 0; bus.halt_req = 0;
    do_reset();
    check("rst_state", 32'(bus.state), 0);
    check("rst_halted", 32'(bus.halted), 1);
    check("rst_done", 32'(bus.instr_done), 0);
    check("rst_illegal", 32'(bus.illegal_class), 0);

    for (int i = 0; i < 9; i++) begin
      cyc(tbl[i].se, tbl[i].st, tbl[i].fi, 1'b0);
      check($sformatf("tbl%0d_state", i),
            32'(bus.state), 32'(tbl[i].exp_state));
      check($sformatf("tbl%0d_done", i),
            32'(bus.instr_done), 32'(tbl[i].exp_done));
      check($sformatf("tbl%0d_halted", i),
            32'(bus.halted), 0);
    end

    // Finish this instruction, then time each class.
    run_instr(4'b0000, 4'b0000, n);
    for (int i = 0; i < 3; i++) begin
      run_instr(lens[i].code, 4'b0000, n);
      check($sformatf("len_%0b", lens[i].code), n,
            lens[i].len);
      check("wrap_state", 32'(bus.state), 1);
    end

    // MOV16 with halt during state_9 parks in IDLE.
    for (int k = 0; k < 8; k++)
      cyc(1'b1, 1'b0, 4'b1010, 1'b0);
    check("mov16_s9", 32'(bus.state), 32'h100);
    cyc(1'b1, 1'b0, 4'b1010, 1'b1);
    check("mov16_s10", 32'(bus.state), 32'h200);
    cyc(1'b1, 1'b0, 4'b1010, 1'b0);
    check("halt_state", 32'(bus.state), 0);
    check("halt_halted", 32'(bus.halted), 1);
    check("halt_done", 32'(bus.instr_done), 1);
    cyc(1'b1, 1'b0, 4'b0000, 1'b0);
    check("idle_hold", 32'(bus.state), 0);
    cyc(1'b1, 1'b1, 4'b0000, 1'b0);
    check("restart", 32'(bus.state), 1);

    // step_en 1,0,0,1 around state_5.
    for (int k = 0; k < 4; k++)
      cyc(1'b1, 1'b0, 4'b0000, 1'b0);
    check("hold_s5", 32'(bus.state), 32'h10);
    for (int k = 0; k < 2; k++) begin
      cyc(1'b0, 1'b1, 4'b0000, 1'b0);
      check("hold_state", 32'(bus.state), 32'h10);
      check("hold_done", 32'(bus.instr_done), 0);
    end
    cyc(1'b1, 1'b0, 4'b0000, 1'b0);
    check("hold_adv", 32'(bus.state), 32'h20);
    run_instr(4'b0000, 4'b0000, n);

    // Illegal code: sticky flag, SHORT length, late
    // fsm_input changes ignored.
    run_instr(4'b0011, 4'b1100, n);
    check("illegal_len", n, 7);
    check("illegal_flag", 32'(bus.illegal_class), 1);
    run_instr(4'b0000, 4'b1011, n);
    check("illegal_sticky", 32'(bus.illegal_class), 1);
    check("legal_len", n, 7);

    // Async reset in state_17 of a GOTO.
    do_reset();
    cyc(1'b1, 1'b1, 4'b0000, 1'b0);
    for (int k = 0; k < 16; k++)
      cyc(1'b1, 1'b0, 4'b1101, 1'b0);
    check("goto_s17", 32'(bus.state), 32'h10000);
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    check("arst_state", 32'(bus.state), 0);
    check("arst_halted", 32'(bus.halted), 1);
    check("arst_illegal", 32'(bus.illegal_class), 0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      cyc($urandom_range(0, 3) != 0,
          $urandom_range(0, 5) == 0,
          4'($urandom),
          $urandom_range(0, 2) == 0);
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule
